// File: rtl/spi_resp_pkg.sv
// rtl/spi_resp_pkg.sv - shared types and constants for the SPI register responder
// FSM encoding, command-byte field positions and the IRQ/IEN register addresses.
package spi_resp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DRD,
    DWR
  } spi_state_t;

  localparam int CMD_ADDR_MSB = 7;
  localparam int CMD_ADDR_LSB = 3;
  localparam int CMD_DIR_BIT  = 1;

  localparam logic [4:0] REG_IRQ = 5'h19;
  localparam logic [4:0] REG_IEN = 5'h1A;

  function automatic logic [4:0] next_addr(input logic [4:0] a, input logic inc);
    return inc ? a + 5'd1 : a;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-flop synchronizer with rise/fall detection
// q is the synchronized level; rise/fall are one-clk pulses derived from q.
module spi_sync_edge #(
  parameter int   SYNC_FF   = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [SYNC_FF-1:0] chain;
  logic               q_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain  <= {SYNC_FF{RESET_VAL}};
      q_prev <= RESET_VAL;
    end else begin
      chain  <= {chain[SYNC_FF-2:0], d};
      q_prev <= chain[SYNC_FF-1];
    end
  end

  assign q    = chain[SYNC_FF-1];
  assign rise = q & ~q_prev;
  assign fall = ~q & q_prev;

endmodule

// File: rtl/spi_reg_responder.sv
// rtl/spi_reg_responder.sv - SPI mode-0 target exposing a 32 x 8-bit register file
// Optional interrupt register pair and irq_n output under SPI_RESP_IRQ_EN.
module spi_reg_responder
  import spi_resp_pkg::*;
#(
  parameter int AUTO_INC = 1,
  parameter int SYNC_FF  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_sclk,
  input  logic       spi_ss_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  input  logic [7:0] status_in,
  input  logic [4:0] loc_addr,
  input  logic       loc_we,
  input  logic [7:0] loc_wdata,
  output logic [7:0] loc_rdata,
  output logic       wr_strobe,
  output logic [4:0] wr_addr,
`ifdef SPI_RESP_IRQ_EN
  output logic       irq_n,
`endif
  output logic [7:0] wr_data
);

  logic       sclk_rise, sclk_fall;
  logic       ss_rise, ss_fall;
  logic       mosi_s;
  logic       unused_sclk_level, unused_ss_level;
  logic [1:0] unused_mosi_edges;

  spi_state_t state;
  logic [2:0] bit_cnt;
  logic [6:0] rx_shift;
  logic [7:0] tx_shift;
  logic [4:0] addr;
  logic       byte_done;
  logic [7:0] regs [32];
  logic [7:0] rx_byte;
  logic [7:0] status_byte;

  spi_sync_edge #(.SYNC_FF(SYNC_FF), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .reset(reset), .d(spi_sclk),
    .q(unused_sclk_level), .rise(sclk_rise), .fall(sclk_fall)
  );

  // ss_n resets to "asserted" so a reset during a transaction cannot fake a
  // falling edge; the bus stays ignored until ss_n goes high and low again.
  spi_sync_edge #(.SYNC_FF(SYNC_FF), .RESET_VAL(1'b0)) u_sync_ss (
    .clk(clk), .reset(reset), .d(spi_ss_n),
    .q(unused_ss_level), .rise(ss_rise), .fall(ss_fall)
  );

  spi_sync_edge #(.SYNC_FF(SYNC_FF), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .reset(reset), .d(spi_mosi),
    .q(mosi_s), .rise(unused_mosi_edges[0]), .fall(unused_mosi_edges[1])
  );

  assign rx_byte   = {rx_shift, mosi_s};
  assign loc_rdata = regs[loc_addr];

`ifdef SPI_RESP_IRQ_EN
  assign status_byte = {status_in[7:1], ~irq_n};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) irq_n <= 1'b1;
    else       irq_n <= ~|(regs[REG_IRQ] & regs[REG_IEN]);
  end
`else
  assign status_byte = status_in;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      bit_cnt     <= 3'd0;
      rx_shift    <= 7'd0;
      tx_shift    <= 8'd0;
      addr        <= 5'd0;
      byte_done   <= 1'b0;
      spi_miso    <= 1'b0;
      spi_miso_oe <= 1'b0;
      wr_strobe   <= 1'b0;
      wr_addr     <= 5'd0;
      wr_data     <= 8'd0;
      for (int i = 0; i < 32; i++) regs[i] <= 8'h00;
    end else begin
      wr_strobe <= 1'b0;
      if (ss_rise) begin
        state       <= IDLE;
        byte_done   <= 1'b0;
        spi_miso    <= 1'b0;
        spi_miso_oe <= 1'b0;
      end else if (ss_fall) begin
        state       <= CMD;
        bit_cnt     <= 3'd0;
        byte_done   <= 1'b0;
        tx_shift    <= status_byte;
        spi_miso    <= status_byte[7];
        spi_miso_oe <= 1'b1;
      end else if (state != IDLE) begin
        if (sclk_rise) begin
          rx_shift <= rx_byte[6:0];
          bit_cnt  <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            byte_done <= 1'b1;
            case (state)
              CMD: begin
                addr  <= rx_byte[CMD_ADDR_MSB:CMD_ADDR_LSB];
                state <= rx_byte[CMD_DIR_BIT] ? DWR : DRD;
              end
              DWR: begin
`ifdef SPI_RESP_IRQ_EN
                if (addr == REG_IRQ) begin
                  regs[addr] <= regs[addr] & ~rx_byte;
                end else begin
                  regs[addr] <= rx_byte;
                end
`else
                regs[addr] <= rx_byte;
`endif
                wr_strobe <= 1'b1;
                wr_addr   <= addr;
                wr_data   <= rx_byte;
                addr      <= next_addr(addr, AUTO_INC != 0);
              end
              default: addr <= next_addr(addr, AUTO_INC != 0);
            endcase
          end
        end else if (sclk_fall) begin
          // Read data is fetched at the first falling edge of each data byte.
          if (byte_done && state == DRD) begin
            tx_shift <= regs[addr];
            spi_miso <= regs[addr][7];
          end else begin
            tx_shift <= {tx_shift[6:0], 1'b0};
            spi_miso <= tx_shift[6];
          end
          byte_done <= 1'b0;
        end
      end

      // Placed after the SPI commit so the local port wins a same-cycle collision.
      if (loc_we) begin
`ifdef SPI_RESP_IRQ_EN
        if (loc_addr == REG_IRQ) begin
          regs[loc_addr] <= regs[loc_addr] | loc_wdata;
        end else begin
          regs[loc_addr] <= loc_wdata;
        end
`else
        regs[loc_addr] <= loc_wdata;
`endif
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_responder.sv
// tb/tb_spi_reg_responder.sv - self-checking bench for spi_reg_responder
`timescale 1ns/1ps
module tb_spi_reg_responder;

  localparam int AUTO_INC = 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       spi_sclk, spi_ss_n, spi_mosi, spi_miso, spi_miso_oe;
  logic [7:0] status_in;
  logic [4:0] loc_addr;
  logic       loc_we;
  logic [7:0] loc_wdata, loc_rdata;
  logic       wr_strobe;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
`ifdef SPI_RESP_IRQ_EN
  logic       irq_n;
`endif

  spi_reg_responder #(.AUTO_INC(AUTO_INC), .SYNC_FF(2)) dut (
    .clk(clk), .reset(reset),
    .spi_sclk(spi_sclk), .spi_ss_n(spi_ss_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .status_in(status_in),
    .loc_addr(loc_addr), .loc_we(loc_we), .loc_wdata(loc_wdata), .loc_rdata(loc_rdata),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr),
`ifdef SPI_RESP_IRQ_EN
    .irq_n(irq_n),
`endif
    .wr_data(wr_data)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [7:0]  cmd;
    logic [15:0] data;
    int          n;
    logic [7:0]  status;
    logic        rd;
    logic [23:0] exp_rx;
    int          nstb;
    logic [9:0]  stb_a;
    logic [15:0] stb_d;
    logic [4:0]  chk_a;
    logic [7:0]  chk_v;
  } vec_t;

  int          checks = 0;
  int          failures = 0;
  logic [7:0]  model [32];
  logic [12:0] got_q [$];
  logic [12:0] exp_q [$];
  logic [7:0]  tx_buf [16];
  logic [7:0]  rx_buf [16];
  int          bit_pos;
  logic        oe_first;
  vec_t        vecs [5];

  always @(negedge clk) if (wr_strobe) got_q.push_back({wr_addr, wr_data});

  initial begin
    #2ms;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] step(input logic [4:0] a);
    return (AUTO_INC != 0) ? 5'((int'(a) + 1) % 32) : a;
  endfunction

  function automatic void model_spi_write(input logic [4:0] a, input logic [7:0] d);
`ifdef SPI_RESP_IRQ_EN
    if (a == 5'h19) model[a] = model[a] & ~d;
    else model[a] = d;
`else
    model[a] = d;
`endif
  endfunction

  function automatic void model_local_write(input logic [4:0] a, input logic [7:0] d);
`ifdef SPI_RESP_IRQ_EN
    if (a == 5'h19) model[a] = model[a] | d;
    else model[a] = d;
`else
    model[a] = d;
`endif
  endfunction

  function automatic logic [7:0] exp_status(input logic [7:0] s);
`ifdef SPI_RESP_IRQ_EN
    return {s[7:1], |(model[5'h19] & model[5'h1A])};
`else
    return s;
`endif
  endfunction

  task automatic local_write(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    loc_addr = a; loc_wdata = d; loc_we = 1'b1;
    @(negedge clk);
    loc_we = 1'b0;
    model_local_write(a, d);
  endtask

  task automatic read_loc(input logic [4:0] a, input string name);
    @(negedge clk);
    loc_addr = a;
    #1;
    check(name, loc_rdata, model[a]);
  endtask

  task automatic compare_strobes(input string name);
    repeat (4) @(negedge clk);
    check({name, " strobe count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({name, " strobe addr/data"}, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  // nbytes whole bytes (command included) then extra_bits of the next byte.
  task automatic spi_xfer(input int nbytes, input int extra_bits);
    int         total;
    logic [7:0] t;
    total = nbytes * 8 + extra_bits;
    @(negedge clk);
    for (int i = 0; i < 16; i++) rx_buf[i] = 8'h00;
    spi_ss_n = 1'b0;
    #100;
    for (int b = 0; b < total; b++) begin
      t = tx_buf[b / 8];
      spi_mosi = t[7 - (b % 8)];
      bit_pos = b;
      #100;
      spi_sclk = 1'b1;
      t = rx_buf[b / 8];
      t[7 - (b % 8)] = spi_miso;
      rx_buf[b / 8] = t;
      if (b == 0) oe_first = spi_miso_oe;
      #100;
      spi_sclk = 1'b0;
    end
    #100;
    spi_ss_n = 1'b1;
    spi_mosi = 1'b0;
    #400;
  endtask

  logic [4:0] a, ai;
  logic       wr;
  logic [7:0] r, exp0;
  int         n, c;

  initial begin
    reset = 1'b1; spi_sclk = 1'b0; spi_ss_n = 1'b1; spi_mosi = 1'b0;
    status_in = 8'h00; loc_addr = 5'd0; loc_we = 1'b0; loc_wdata = 8'h00;
    bit_pos = -1; oe_first = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = 8'h00;

    vecs[0] = '{cmd:8'h2A, data:16'h003C, n:1, status:8'h00, rd:1'b0, exp_rx:24'h000000,
                nstb:1, stb_a:10'h005, stb_d:16'h003C, chk_a:5'h05, chk_v:8'h3C};
    vecs[1] = '{cmd:8'h28, data:16'h0000, n:1, status:8'hA5, rd:1'b1, exp_rx:24'h003CA5,
                nstb:0, stb_a:10'h000, stb_d:16'h0000, chk_a:5'h05, chk_v:8'h3C};
    vecs[2] = '{cmd:8'hFA, data:16'h2211, n:2, status:8'h5A, rd:1'b0, exp_rx:24'h00005A,
                nstb:2, stb_a:10'h01F, stb_d:16'h2211, chk_a:5'h1F, chk_v:8'h11};
    vecs[3] = '{cmd:8'hF8, data:16'h0000, n:2, status:8'h0F, rd:1'b1, exp_rx:24'h22110F,
                nstb:0, stb_a:10'h000, stb_d:16'h0000, chk_a:5'h00, chk_v:8'h22};
    vecs[4] = '{cmd:8'h57, data:16'h00C3, n:1, status:8'h81, rd:1'b0, exp_rx:24'h000081,
                nstb:1, stb_a:10'h00A, stb_d:16'h00C3, chk_a:5'h0A, chk_v:8'hC3};

    repeat (5) @(negedge clk);
    check("reset wr_strobe", wr_strobe, 1'b0);
    check("reset miso_oe", spi_miso_oe, 1'b0);
    check("reset miso", spi_miso, 1'b0);
    check("reset wr_addr", wr_addr, 5'd0);
    check("reset wr_data", wr_data, 8'd0);
`ifdef SPI_RESP_IRQ_EN
    check("reset irq_n", irq_n, 1'b1);
`endif
    reset = 1'b0;
    read_loc(5'd0, "reset reg0");
    read_loc(5'd31, "reset reg31");

    for (int v = 0; v < 5; v++) begin
      tx_buf[0] = vecs[v].cmd;
      tx_buf[1] = vecs[v].data[7:0];
      tx_buf[2] = vecs[v].data[15:8];
      status_in = vecs[v].status;
      exp0 = exp_status(vecs[v].exp_rx[7:0]);
      spi_xfer(vecs[v].n + 1, 0);
      check($sformatf("vec%0d status byte", v), rx_buf[0], exp0);
      check($sformatf("vec%0d oe during", v), oe_first, 1'b1);
      check($sformatf("vec%0d oe after", v), spi_miso_oe, 1'b0);
      check($sformatf("vec%0d miso after", v), spi_miso, 1'b0);
      if (vecs[v].rd)
        for (int i = 1; i <= vecs[v].n; i++)
          check($sformatf("vec%0d read byte%0d", v, i), rx_buf[i], vecs[v].exp_rx[8*i +: 8]);
      for (int i = 0; i < vecs[v].nstb; i++) begin
        exp_q.push_back({vecs[v].stb_a[5*i +: 5], vecs[v].stb_d[8*i +: 8]});
        model_spi_write(vecs[v].stb_a[5*i +: 5], vecs[v].stb_d[8*i +: 8]);
      end
      compare_strobes($sformatf("vec%0d", v));
      @(negedge clk);
      loc_addr = vecs[v].chk_a;
      #1;
      check($sformatf("vec%0d loc_rdata", v), loc_rdata, vecs[v].chk_v);
    end

    // Partial byte must be discarded, then the bus must work normally.
    tx_buf[0] = 8'h3A; tx_buf[1] = 8'hFF; status_in = 8'h00;
    spi_xfer(1, 5);
    compare_strobes("partial");
    read_loc(5'd7, "partial reg7");
    tx_buf[1] = 8'h6B;
    spi_xfer(2, 0);
    exp_q.push_back({5'd7, 8'h6B});
    model_spi_write(5'd7, 8'h6B);
    compare_strobes("after partial");
    read_loc(5'd7, "after partial reg7");

    // Local write held across the SPI commit cycle, dropped right after it.
    tx_buf[0] = 8'h1A; tx_buf[1] = 8'h55; bit_pos = -1;
    fork
      spi_xfer(2, 0);
      begin
        c = 0;
        while (bit_pos < 15 && c < 5000) begin @(negedge clk); c++; end
        loc_addr = 5'd3; loc_wdata = 8'h99; loc_we = 1'b1;
        c = 0;
        while (!wr_strobe && c < 200) begin @(negedge clk); c++; end
        loc_we = 1'b0;
        check("collision strobe seen", wr_strobe, 1'b1);
      end
    join
    model_spi_write(5'd3, 8'h55);
    model_local_write(5'd3, 8'h99);
    exp_q.push_back({5'd3, 8'h55});
    compare_strobes("collision");
    read_loc(5'd3, "collision reg3");

`ifdef SPI_RESP_IRQ_EN
    local_write(5'h1A, 8'h01);
    local_write(5'h19, 8'h01);
    repeat (3) @(negedge clk);
    check("irq asserted", irq_n, 1'b0);
    tx_buf[0] = 8'hCA; tx_buf[1] = 8'h01;
    spi_xfer(2, 0);
    exp_q.push_back({5'h19, 8'h01});
    model_spi_write(5'h19, 8'h01);
    compare_strobes("irq clear");
    check("irq released", irq_n, 1'b1);
`endif

    for (int k = 0; k < 30; k++) begin
      a  = 5'($urandom_range(0, 31));
      n  = $urandom_range(1, 4);
      wr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) local_write(5'($urandom_range(0, 31)), 8'($urandom));
      status_in = 8'($urandom);
      r = 8'($urandom);
      tx_buf[0] = {a, r[0], wr, r[1]};
      for (int i = 1; i <= n; i++) tx_buf[i] = 8'($urandom);
      exp0 = exp_status(status_in);
      spi_xfer(n + 1, 0);
      check($sformatf("rand%0d status byte", k), rx_buf[0], exp0);
      ai = a;
      for (int i = 1; i <= n; i++) begin
        if (wr) begin
          exp_q.push_back({ai, tx_buf[i]});
          model_spi_write(ai, tx_buf[i]);
        end else begin
          check($sformatf("rand%0d read byte%0d", k, i), rx_buf[i], model[ai]);
        end
        ai = step(ai);
      end
      compare_strobes($sformatf("rand%0d", k));
    end

    for (int i = 0; i < 32; i++) read_loc(5'(i), $sformatf("final reg%0d", i));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
